prog_bound_counter: RTL
=======================

// Module: prog_bound_counter
// PURPOSE
//   Parametrised up/down counter with runtime-programmable bounds [lo,hi], step size and
//   end-of-range mode (wrap, saturate, one-shot). Successor to the fixed 0..2^N-1 binary counter.
//   Used for timers, address sequencers and prescalers wherever a non-power-of-2 range is needed.
// PARAMETERS
//   N        4   counter/bound/load width in bits
//   STEP_W   2   width of step input; legal step 0..2^STEP_W-1
// PORTS
//   clk       in   1       clock; all state updates on rising edge
//   rst_n     in   1       asynchronous active-low reset
//   syn_clr   in   1       synchronous clear: q <= lo
//   load      in   1       synchronous load of d (clamped to [lo,hi])
//   d         in   N       load value
//   en        in   1       count enable
//   up        in   1       1 = count up, 0 = count down
//   step      in   STEP_W  increment/decrement amount
//   lo        in   N       lower bound (inclusive, unsigned)
//   hi        in   N       upper bound (inclusive, unsigned)
//   mode      in   2       00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved (acts as SATURATE)
//   q         out  N       count value
//   max_tick  out  1       comb: q == hi
//   min_tick  out  1       comb: q == lo
//   bound_tick out 1       registered 1-cycle pulse: previous edge hit a bound (wrap/sat/halt)
//   halted    out  1       1 while FSM in HALT
//   cfg_err   out  1       comb: lo > hi
// BEHAVIOUR
//   Reset: q=0, bound_tick=0, FSM=RUN, halted=0. Asynchronous assert, sync to clk on release.
//   Priority per edge: cfg_err > syn_clr > load > en. cfg_err=1: q holds, bound_tick=0.
//   syn_clr: q<=lo, FSM->RUN. load: q<=max(lo,min(d,hi)), FSM->RUN. Latency 1 cycle.
//   FSM: RUN -> HALT on one-shot bound event; HALT -> RUN only via syn_clr/load; rst_n -> RUN.
//   In HALT, en ignored, q holds.
//   Count (RUN, en=1): arithmetic in N+1 bits, no silent overflow.
//     up:   nxt=q+step; if nxt>hi: WRAP q<=lo; SAT/ONESHOT q<=hi; bound_tick<=1.
//     down: if step>q-lo: WRAP q<=hi; SAT/ONESHOT q<=lo; bound_tick<=1; else q<=q-step.
//     nxt==hi exactly (or q-step==lo) is NOT a bound event: q<=hi/lo, bound_tick=0.
//     Saturated at bound and counting further: q holds, bound_tick=1 each such cycle.
//     ONESHOT bound event additionally moves FSM to HALT (halted=1 next cycle).
//     step=0: q holds, no bound event.
//   q outside [lo,hi] (bounds changed at runtime) with en=1 and RUN: q<=lo if up, hi if down,
//     bound_tick=0, regardless of mode.
//   en=0: q holds, bound_tick=0. bound_tick is 0 in every cycle not listed above.
//   lo==hi: any nonzero step is a bound event; q stays lo.
//   Reset mid-count: q->0 immediately; first post-reset count with lo>0 applies out-of-range rule.
// STRUCTURE
//   Shared package: mode encodings (MODE_WRAP/SAT/ONESHOT), FSM state enum (ST_RUN, ST_HALT).
//   One sub-module: prog_bound_next (combinational next-value + bound-event calculation,
//   up/down, N+1-bit compare); top holds q register, FSM, priority mux, bound_tick register.
// TESTING (N=4, STEP_W=2, lo=3, hi=12 unless stated)
//   1 Reset: rst_n=0 mid-count at q=9 -> q=0 same cycle, halted=0, bound_tick=0; en=1 up -> q=3.
//   2 Load/clr: load d=15 -> q=12, max_tick=1; load d=1 -> q=3; syn_clr+load same edge -> q=3.
//   3 WRAP up step=2 from q=9: 11,3 (bound_tick=1 on the 11->3 edge); down step=3 from 4 -> 12.
//   4 SATURATE up step=3 from 9: 12 (no tick), 12 (tick=1), 12 (tick=1); en=0 -> tick=0.
//   5 ONESHOT down step=1 from 5: 4,3,3 with bound_tick=1 + halted=1; en/up toggles no effect;
//     load d=7 -> q=7, halted=0.
//   6 Config: lo=12, hi=3 -> cfg_err=1, q holds under en/load; lo=hi=6 step=1 -> q=6, tick=1.

Source files
------------

// File: rtl/prog_bound_counter_pkg.sv
// Shared encodings for the programmable-bound counter: end-of-range modes and FSM states.
// Pure declarations; no logic, latency or backpressure of its own.
package prog_bound_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/prog_bound_counter_if.sv
// Control/status bundle of the counter; the master drives configuration, the slave returns status.
// No handshake: the counter samples every input on each rising edge.
interface prog_bound_counter_if #(
  parameter int N      = 4,
  parameter int STEP_W = 2
);
  logic              syn_clr;
  logic              load;
  logic [N-1:0]      d;
  logic              en;
  logic              up;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      lo;
  logic [N-1:0]      hi;
  logic [1:0]        mode;
  logic [N-1:0]      q;
  logic              max_tick;
  logic              min_tick;
  logic              bound_tick;
  logic              halted;
  logic              cfg_err;

  modport master (
    output syn_clr, load, d, en, up, step, lo, hi, mode,
    input  q, max_tick, min_tick, bound_tick, halted, cfg_err
  );

  modport slave (
    input  syn_clr, load, d, en, up, step, lo, hi, mode,
    output q, max_tick, min_tick, bound_tick, halted, cfg_err
  );
endinterface

// File: rtl/prog_bound_next.sv
// Combinational next count and bound-event detection for one enabled step, up or down.
// Zero latency; no backpressure.
module prog_bound_next
  import prog_bound_counter_pkg::*;
#(
  parameter int N      = 4,
  parameter int STEP_W = 2
) (
  input  logic [N-1:0]      q_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [N-1:0]      lo_i,
  input  logic [N-1:0]      hi_i,
  input  logic              up_i,
  input  logic [1:0]        mode_i,
  output logic [N-1:0]      nxt_o,
  output logic              bound_evt_o
);

  logic [N:0]   step_ext;
  logic [N:0]   sum;
  logic [N-1:0] room_dn;
  logic         out_of_range;
  logic         wrap;

  assign step_ext     = {{(N + 1 - STEP_W){1'b0}}, step_i};
  assign sum          = {1'b0, q_i} + step_ext;
  assign room_dn      = q_i - lo_i;
  assign out_of_range = (q_i < lo_i) || (q_i > hi_i);
  assign wrap         = (mode_i == MODE_WRAP);

  always_comb begin
    nxt_o       = q_i;
    bound_evt_o = 1'b0;
    if (out_of_range) begin
      // Bounds moved under the count: snap to the edge we are heading away from.
      nxt_o = up_i ? lo_i : hi_i;
    end else if (up_i) begin
      if (sum > {1'b0, hi_i}) begin
        nxt_o       = wrap ? lo_i : hi_i;
        bound_evt_o = 1'b1;
      end else begin
        nxt_o = sum[N-1:0];
      end
    end else begin
      if (step_ext > {1'b0, room_dn}) begin
        nxt_o       = wrap ? hi_i : lo_i;
        bound_evt_o = 1'b1;
      end else begin
        nxt_o = q_i - step_ext[N-1:0];
      end
    end
  end

endmodule

// File: rtl/prog_bound_counter.sv
// Up/down counter with runtime bounds [lo,hi], step and wrap/saturate/one-shot end mode.
// 1-cycle latency from any control input to q; no backpressure (inputs sampled every edge).
module prog_bound_counter
  import prog_bound_counter_pkg::*;
#(
  parameter int N      = 4,
  parameter int STEP_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prog_bound_counter_if.slave  bus
);

  logic [N-1:0] q_q, q_d;
  logic         tick_q, tick_d;
  state_t       st_q, st_d;
  logic [N-1:0] nxt;
  logic         bound_evt;
  logic [N-1:0] ld_min;
  logic [N-1:0] ld_val;
  logic         cfg_err;
  logic         count_ok;

  prog_bound_next #(.N(N), .STEP_W(STEP_W)) u_next (
    .q_i         (q_q),
    .step_i      (bus.step),
    .lo_i        (bus.lo),
    .hi_i        (bus.hi),
    .up_i        (bus.up),
    .mode_i      (bus.mode),
    .nxt_o       (nxt),
    .bound_evt_o (bound_evt)
  );

  assign cfg_err  = (bus.lo > bus.hi);
  assign ld_min   = (bus.d > bus.hi) ? bus.hi : bus.d;
  assign ld_val   = (ld_min < bus.lo) ? bus.lo : ld_min;
  assign count_ok = !cfg_err && !bus.syn_clr && !bus.load && bus.en && (st_q == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_RUN;
      q_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      q_q    <= q_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (!cfg_err) begin
      if (bus.syn_clr || bus.load) begin
        st_d = ST_RUN;
      end else if (count_ok && bound_evt && (bus.mode == MODE_ONESHOT)) begin
        st_d = ST_HALT;
      end
    end
  end

  // Datapath priority: bad config freezes everything, then clear, load, count.
  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    if (!cfg_err) begin
      if (bus.syn_clr) begin
        q_d = bus.lo;
      end else if (bus.load) begin
        q_d = ld_val;
      end else if (count_ok) begin
        q_d    = nxt;
        tick_d = bound_evt;
      end
    end
  end

  always_comb begin
    bus.halted = (st_q == ST_HALT);
  end

  assign bus.q          = q_q;
  assign bus.bound_tick = tick_q;
  assign bus.max_tick   = (q_q == bus.hi);
  assign bus.min_tick   = (q_q == bus.lo);
  assign bus.cfg_err    = cfg_err;

endmodule
